// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: scan state,
// debug view and the active-low segment glyphs ({g,f,e,d,c,b,a}).
package sseg_scan_ctrl_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  typedef struct packed {
    scan_state_t state;
    logic [1:0]  idx;
    logic        pend_v;
  } scan_dbg_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module sseg_hex_lut
  import sseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode display scanner with blank phases, leading-zero
// blanking and frame-synchronous value update (no torn frames).
module sseg_scan_ctrl
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output scan_dbg_t   dbg
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam scan_state_t AFTER_ON = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;

  scan_state_t state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          boundary;
  logic [15:0]   disp, pending;
  logic          pend_v;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          lz;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    boundary = 1'b0;
    case (state)
      S_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt == BLK_LAST) begin
          state_nx = S_ON;
          cnt_nx   = '0;
        end
      end
      S_ON: begin
        if (cnt == DIG_LAST) begin
          state_nx = AFTER_ON;
          idx_nx   = idx + 2'd1;
          cnt_nx   = '0;
          boundary = (idx == 2'd3);
        end
      end
      default: state_nx = S_BLANK;
    endcase
  end

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    nib = disp[4*idx +: 4];
    lz  = 1'b0;
    case (idx)
      2'd1: lz = (disp[15:4] == 12'h000);
      2'd2: lz = (disp[15:8] == 8'h00);
      2'd3: lz = (disp[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
  end

  sseg_hex_lut u_lut (
    .nib (nib),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      disp       <= 16'h0000;
      pending    <= 16'h0000;
      pend_v     <= 1'b0;
      an         <= 4'hF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      if (boundary && pend_v) begin
        disp   <= pending;
        pend_v <= 1'b0;
      end
      // A load coinciding with the boundary wins over the clear above.
      if (load) begin
        pending <= value;
        pend_v  <= 1'b1;
      end
      if (state == S_ON) begin
        an  <= ~(4'b0001 << idx);
        seg <= (blank_lz && lz) ? SEG_BLANK : glyph;
        dp  <= ~dp_in[idx];
      end else begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
      load_ack   <= boundary && pend_v;
      frame_done <= boundary;
    end
  end

  assign dbg = '{state: state, idx: idx, pend_v: pend_v};

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random loads, checked
// against a frame-position model of the scan and display registers.
module tb_sseg_scan_ctrl;
  import sseg_scan_ctrl_pkg::*;

  localparam int DC = 4;
  localparam int BC = 2;
  localparam int SLOT = DC + BC;
  localparam int FRAME = 4 * SLOT;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic        load_ack, frame_done, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  scan_dbg_t   dbg;

  sseg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .dbg        (dbg)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // model: m_n counts clock edges since reset released
  int          m_n = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, m_n, obs, exp);
    end
  endtask

  // Predicts the pins after the coming edge, then advances model registers.
  task automatic model_edge();
    int q, dig;
    logic lit, bnd, lzb;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ack;
    if (!rst_n) begin
      m_n = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end else begin
      m_n++;
      q   = m_n - 1;
      dig = (q / SLOT) % 4;
      lit = (q % SLOT) >= BC;
      bnd = (m_n % FRAME) == 0;
      lzb = blank_lz && dig > 0 && ((m_disp >> (4 * dig)) == 16'h0);
      e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
      e_seg = !lit ? 7'h7F : (lzb ? 7'h7F : glyph_tab[(m_disp >> (4 * dig)) & 16'hF]);
      e_dp  = lit ? ~dp_in[dig] : 1'b1;
      e_ack = bnd && m_pv;
      exp_q.push_back({e_an, e_seg, e_dp, e_ack, bnd});
      if (bnd && m_pv) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (load) begin
        m_pend = value;
        m_pv   = 1'b1;
      end
    end
  endtask

  // driver
  task automatic step(input logic ld, input logic [15:0] v);
    logic [13:0] e;
    @(negedge clk);
    load  = ld;
    value = v;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("an", {12'h0, an}, {12'h0, e[13:10]});
    check("seg", {9'h0, seg}, {9'h0, e[9:3]});
    check("dp", {15'h0, dp}, {15'h0, e[2]});
    check("load_ack", {15'h0, load_ack}, {15'h0, e[1]});
    check("frame_done", {15'h0, frame_done}, {15'h0, e[0]});
    load = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0);
  endtask

  // Advance so the next step() lands on an edge with m_n % FRAME == ph.
  task automatic run_to(input int ph);
    for (int i = 0; i < FRAME && ((m_n + 1) % FRAME) != ph; i++) step(1'b0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; load = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(FRAME);

    // load mid-frame, shown from next frame
    run_to(7);
    step(1'b1, 16'h12AF);
    run(2 * FRAME);

    // leading-zero blanking
    blank_lz = 1'b1;
    step(1'b1, 16'h0050);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // two loads in one frame, last wins
    run_to(3);
    step(1'b1, 16'h1111);
    run(5);
    step(1'b1, 16'h2222);
    run(2 * FRAME);

    // load on the boundary cycle with nothing pending
    dp_in = 4'b0100;
    run_to(0);
    step(1'b1, 16'h3333);
    run(3 * FRAME);
    dp_in = 4'b0000;

    // reset during digit 2 with a pending value
    run_to(1);
    step(1'b1, 16'h4567);
    run_to(2 * SLOT + BC + 1);
    run(1);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(2 * FRAME);

    // random traffic
    for (int i = 0; i < 1200; i++) begin
      if ((i % FRAME) == 0) begin
        dp_in    = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 19) == 0)
        step(1'b1, 16'($urandom) >> (4 * $urandom_range(0, 4)));
      else
        step(1'b0, 16'($urandom));
    end
    rst_n = 1'b1;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
